ready_waitstate_ctrl: RTL and testbench
=======================================

// Module: ready_waitstate_ctrl
// PURPOSE
//  Registered, multi-source successor of the phi2 ready logic.
//  - Inserts a programmable number of wait states per read bus cycle.
//  - Combines NCH external ready sources under an enable mask.
//  - Never stalls a write cycle.
//  - Bounds every stall with a timeout watchdog and keeps a saturating stall counter.
//  - Sits between the bus/address-decode logic and the CPU core rdy input.
// PARAMETERS
//  NCH      2    number of external ready sources
//  WS_W     4    width of ws_count / internal wait-state counter
//  TIMEOUT  255  max consecutive stall cycles before forced release (>=2)
//  CNT_W    16   width of stall_total counter
// PORTS
//  clk_2        in   1      phi2 clock; all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  READY_IN     in   NCH    external ready sources (1 = ready)
//  ch_en        in   NCH    per-source enable mask; disabled source counts as ready
//  rw_n         in   1      read-not-write of current cycle (0 = write)
//  cyc_start    in   1      1-cycle strobe: a new bus cycle begins
//  ws_count     in   WS_W   wait states for the cycle flagged by cyc_start
//  timeout_clr  in   1      clears timeout_flag and stall_total
//  rdy          out  1      registered ready to CPU core (1 = proceed)
//  stalled      out  1      1 while FSM is in WS or EXT
//  timeout_flag out  1      sticky: a stall was force-released
//  stall_total  out  CNT_W  saturating count of cycles with rdy=0
// BEHAVIOUR
//  Reset: state=IDLE, rdy=1, stalled=0, timeout_flag=0, stall_total=0,
//   internal ws_cnt=0, stall_cnt=0.
//  ext_ok = &(READY_IN | ~ch_en); all sources masked -> ext_ok=1.
//  Outputs are registered: each output reflects inputs sampled at the previous edge.
//  FSM states IDLE, WS, EXT; priority per edge, high to low:
//   1 reset.
//   2 rw_n=0 (write): ->IDLE, rdy=1, ws_cnt=0, stall_cnt=0. Applies in any state.
//   3 stall_cnt==TIMEOUT-1 and next rdy would be 0: ->IDLE, rdy=1, timeout_flag=1.
//   4 normal transitions below.
//  IDLE, cyc_start=1, rw_n=1:
//   - ws_count!=0: ->WS, ws_cnt=ws_count, rdy=0.
//   - ws_count==0 and !ext_ok: ->EXT, rdy=0.
//   - otherwise stay IDLE, rdy=1.
//  IDLE, cyc_start=0: stay IDLE, rdy=1.
//  WS: ws_cnt decrements each edge, rdy=0.
//   - At ws_cnt==1: ->IDLE with rdy=1 if ext_ok, else ->EXT.
//   - rdy is therefore low for exactly ws_count cycles when ext_ok is held high.
//  EXT: rdy=0 until ext_ok is sampled 1, then ->IDLE, rdy=1 on that edge.
//  cyc_start outside IDLE is ignored; the write override still applies.
//  stall_cnt: +1 on each edge where the next rdy=0; cleared whenever the next rdy=1.
//   Guarantees at most TIMEOUT consecutive low cycles of rdy.
//  stall_total: +1 per cycle with rdy=0; saturates at all-ones; no wrap.
//  timeout_clr: clears stall_total and timeout_flag.
//   - Same-edge new timeout: timeout_flag=1 (set wins).
//   - Same-edge stall: stall_total=1 (increment applied after clear).
//  stalled = (state!=IDLE), registered alongside rdy.
//  Reset asserted mid-stall: next edge rdy=1, IDLE; stall progress is discarded.
// TESTING
//  T1 reset; cyc_start, rw_n=1, ws_count=3, all ready
//     -> rdy 0 for exactly 3 cycles, then 1; stall_total=3.
//  T2 ws_count=2, READY_IN[1]=0 until cycle 6
//     -> rdy 0 through cycle 6, 1 on the edge after READY_IN[1] rises.
//  T3 READY_IN=0, ch_en=0, ws_count=0 -> rdy stays 1; stalled never asserts.
//  T4 in WS with ws_cnt=5, drive rw_n=0 for 1 cycle
//     -> next edge rdy=1, state IDLE, remaining wait states dropped.
//  T5 TIMEOUT=8, READY_IN held 0
//     -> rdy low exactly 8 cycles, then 1; timeout_flag=1;
//        timeout_clr -> flag=0, stall_total=0.
//  T6 CNT_W=4, force >15 stall cycles -> stall_total holds 15, no wrap.

Source files
------------

// File: rtl/ready_waitstate_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ready_waitstate_ctrl_if
//  Description : Bus-side signal bundle for ready_waitstate_ctrl.
//                master : bus / address-decode side (drives cycle info and
//                         external ready sources, observes rdy and status)
//                slave  : the ready controller itself
//  Signals     : READY_IN[NCH], ch_en[NCH], rw_n, cyc_start, ws_count[WS_W],
//                timeout_clr, rdy, stalled, timeout_flag, stall_total[CNT_W]
//  Revision    : 1.0 - initial release
// ============================================================================
interface ready_waitstate_ctrl_if #(
   parameter int NCH   = 2,
   parameter int WS_W  = 4,
   parameter int CNT_W = 16
);
   logic [NCH-1:0]   READY_IN;
   logic [NCH-1:0]   ch_en;
   logic             rw_n;
   logic             cyc_start;
   logic [WS_W-1:0]  ws_count;
   logic             timeout_clr;
   logic             rdy;
   logic             stalled;
   logic             timeout_flag;
   logic [CNT_W-1:0] stall_total;

   modport master (
      output READY_IN, ch_en, rw_n, cyc_start, ws_count, timeout_clr,
      input  rdy, stalled, timeout_flag, stall_total
   );

   modport slave (
      input  READY_IN, ch_en, rw_n, cyc_start, ws_count, timeout_clr,
      output rdy, stalled, timeout_flag, stall_total
   );
endinterface
`default_nettype wire

// File: rtl/ready_waitstate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ready_waitstate_ctrl
//  Description : Registered multi-source ready generator for the CPU core.
//                Inserts programmable wait states on read cycles, merges NCH
//                masked external ready sources, never stalls writes, bounds
//                every stall with a watchdog and keeps a saturating count of
//                stalled cycles.
//  Ports       : clk_2  - phi2 clock, all state changes on rising edge
//                reset  - synchronous active-high reset
//                bus    - ready_waitstate_ctrl_if.slave (cycle info in,
//                         rdy / stalled / timeout_flag / stall_total out)
//  Revision    : 1.0 - initial release
// ============================================================================
module ready_waitstate_ctrl #(
   parameter int NCH     = 2,
   parameter int WS_W    = 4,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  wire logic              clk_2,
   input  wire logic              reset,
   ready_waitstate_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WS   = 2'd1,
      ST_EXT  = 2'd2
   } state_t;

   localparam int                  c_STALL_W    = $clog2(TIMEOUT + 1);
   localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]    c_TOTAL_MAX  = '1;
   localparam logic [WS_W-1:0]     c_WS_ONE     = WS_W'(1);

   state_t               r_state;
   logic [WS_W-1:0]      r_ws_cnt;
   logic [c_STALL_W-1:0] r_stall_cnt;
   logic                 r_rdy;
   logic                 r_stalled;
   logic                 r_timeout_flag;
   logic [CNT_W-1:0]     r_stall_total;

   logic                 w_ext_ok;
   state_t               w_nxt_state;
   logic [WS_W-1:0]      w_nxt_ws_cnt;
   logic                 w_nxt_rdy;
   logic                 w_timeout;
   logic [c_STALL_W-1:0] w_nxt_stall_cnt;
   logic [CNT_W-1:0]     w_nxt_total;
   logic                 w_nxt_flag;

   // A masked-off source never holds the bus.
   assign w_ext_ok = &(bus.READY_IN | ~bus.ch_en);

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_ws_cnt = r_ws_cnt;
      w_nxt_rdy    = 1'b1;
      w_timeout    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.cyc_start && bus.rw_n) begin
               if (bus.ws_count != '0) begin
                  w_nxt_state  = ST_WS;
                  w_nxt_ws_cnt = bus.ws_count;
                  w_nxt_rdy    = 1'b0;
               end else if (!w_ext_ok) begin
                  w_nxt_state = ST_EXT;
                  w_nxt_rdy   = 1'b0;
               end
            end
         end
         ST_WS: begin
            // ws_cnt holds the wait states still owed including this one,
            // so the last one expires when it reads 1.
            if (r_ws_cnt <= c_WS_ONE) begin
               w_nxt_ws_cnt = '0;
               if (w_ext_ok) begin
                  w_nxt_state = ST_IDLE;
               end else begin
                  w_nxt_state = ST_EXT;
                  w_nxt_rdy   = 1'b0;
               end
            end else begin
               w_nxt_ws_cnt = r_ws_cnt - c_WS_ONE;
               w_nxt_rdy    = 1'b0;
            end
         end
         ST_EXT: begin
            if (w_ext_ok) begin
               w_nxt_state = ST_IDLE;
            end else begin
               w_nxt_rdy = 1'b0;
            end
         end
         default: begin
            w_nxt_state  = ST_IDLE;
            w_nxt_ws_cnt = '0;
         end
      endcase

      // A write always proceeds; it overrides any pending stall.
      if (!bus.rw_n) begin
         w_nxt_state  = ST_IDLE;
         w_nxt_ws_cnt = '0;
         w_nxt_rdy    = 1'b1;
      end else if (!w_nxt_rdy && (r_stall_cnt == c_STALL_LAST)) begin
         w_nxt_state  = ST_IDLE;
         w_nxt_ws_cnt = '0;
         w_nxt_rdy    = 1'b1;
         w_timeout    = 1'b1;
      end

      // stall_cnt counts the low cycles already completed ahead of the one
      // now in progress, so a release on reaching TIMEOUT-1 leaves rdy low
      // for TIMEOUT cycles at most.
      if (w_nxt_rdy || r_rdy) begin
         w_nxt_stall_cnt = '0;
      end else begin
         w_nxt_stall_cnt = r_stall_cnt + c_STALL_W'(1);
      end

      // Clear first, then count, so a stall on the clearing edge reads 1.
      w_nxt_total = bus.timeout_clr ? '0 : r_stall_total;
      if (!w_nxt_rdy && (w_nxt_total != c_TOTAL_MAX)) begin
         w_nxt_total = w_nxt_total + CNT_W'(1);
      end

      // A new timeout wins over a simultaneous clear.
      w_nxt_flag = w_timeout | (r_timeout_flag & ~bus.timeout_clr);
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_ws_cnt       <= '0;
         r_stall_cnt    <= '0;
         r_rdy          <= 1'b1;
         r_stalled      <= 1'b0;
         r_timeout_flag <= 1'b0;
         r_stall_total  <= '0;
      end else begin
         r_state        <= w_nxt_state;
         r_ws_cnt       <= w_nxt_ws_cnt;
         r_stall_cnt    <= w_nxt_stall_cnt;
         r_rdy          <= w_nxt_rdy;
         r_stalled      <= (w_nxt_state != ST_IDLE);
         r_timeout_flag <= w_nxt_flag;
         r_stall_total  <= w_nxt_total;
      end
   end

   assign bus.rdy          = r_rdy;
   assign bus.stalled      = r_stalled;
   assign bus.timeout_flag = r_timeout_flag;
   assign bus.stall_total  = r_stall_total;

endmodule
`default_nettype wire

// File: tb/tb_ready_waitstate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ready_waitstate_ctrl
//  Description : Self-checking bench for ready_waitstate_ctrl. Each cycle the
//                stimulus and the expected registered outputs are queued
//                together; after the edge the expectation is popped and
//                compared against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ready_waitstate_ctrl;

   localparam int c_NCH   = 2;
   localparam int c_WS_W  = 4;
   localparam int c_TO    = 8;
   localparam int c_CNT_W = 4;

   typedef struct packed {
      logic             rdy;
      logic             stalled;
      logic             tflag;
      logic [c_CNT_W-1:0] total;
   } exp_t;

   typedef struct packed {
      logic             rst;
      logic             cs;
      logic             rw;
      logic [c_WS_W-1:0] ws;
      logic [1:0]       rin;
      logic [1:0]       en;
      logic             clr;
      logic             e_rdy;
      logic             e_st;
      logic             e_to;
   } stim_t;

   logic clk_2 = 1'b0;
   logic rst   = 1'b1;

   exp_t             q[$];
   int               n_tests = 0;
   int               n_fail  = 0;
   logic             m_flag  = 1'b0;
   logic [c_CNT_W-1:0] m_total = '0;

   ready_waitstate_ctrl_if #(.NCH(c_NCH), .WS_W(c_WS_W), .CNT_W(c_CNT_W)) bus ();

   ready_waitstate_ctrl #(
      .NCH     (c_NCH),
      .WS_W    (c_WS_W),
      .TIMEOUT (c_TO),
      .CNT_W   (c_CNT_W)
   ) dut (
      .clk_2 (clk_2),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk_2 = ~clk_2;

   function automatic stim_t idle();
      stim_t s;
      s       = '0;
      s.rw    = 1'b1;
      s.rin   = 2'b11;
      s.en    = 2'b11;
      s.e_rdy = 1'b1;
      return s;
   endfunction

   // Drive one cycle, queue its expected outputs, advance past the edge.
   task automatic cyc(input stim_t s);
      exp_t e;
      rst             = s.rst;
      bus.cyc_start   = s.cs;
      bus.rw_n        = s.rw;
      bus.ws_count    = s.ws;
      bus.READY_IN    = s.rin;
      bus.ch_en       = s.en;
      bus.timeout_clr = s.clr;
      if (s.rst) begin
         m_total = '0;
         m_flag  = 1'b0;
      end else begin
         if (s.clr) m_total = '0;
         if (s.e_to) m_flag = 1'b1;
         else if (s.clr) m_flag = 1'b0;
         if (!s.e_rdy && (m_total != 4'hF)) m_total = m_total + 4'd1;
      end
      e.rdy     = s.e_rdy;
      e.stalled = s.e_st;
      e.tflag   = m_flag;
      e.total   = m_total;
      q.push_back(e);
      @(posedge clk_2);
      #1;
   endtask

   task automatic test_reset();
      stim_t s;
      exp_t  e, g;
      for (int k = 0; k < 2; k++) begin
         s = idle();
         s.rst = 1'b1;
         cyc(s);
         e = q.pop_front();
         g = {bus.rdy, bus.stalled, bus.timeout_flag, bus.stall_total};
         n_tests++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL reset[%0d]: got rdy=%b stalled=%b tflag=%b total=%0d, want rdy=%b stalled=%b tflag=%b total=%0d",
                     k, g.rdy, g.stalled, g.tflag, g.total, e.rdy, e.stalled, e.tflag, e.total);
         end
      end
   endtask

   task automatic test_wait_states();
      stim_t s;
      exp_t  e, g;
      int    wsv[4] = '{1, 2, 3, 5};
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k <= wsv[p]; k++) begin
            s = idle();
            if (k == 0) begin
               s.cs  = 1'b1;
               s.ws  = c_WS_W'(wsv[p]);
               s.clr = 1'b1;
            end
            s.e_rdy = (k == wsv[p]);
            s.e_st  = (k <  wsv[p]);
            cyc(s);
            e = q.pop_front();
            g = {bus.rdy, bus.stalled, bus.timeout_flag, bus.stall_total};
            n_tests++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL wait_states ws=%0d[%0d]: got rdy=%b stalled=%b tflag=%b total=%0d, want rdy=%b stalled=%b tflag=%b total=%0d",
                        wsv[p], k, g.rdy, g.stalled, g.tflag, g.total, e.rdy, e.stalled, e.tflag, e.total);
            end
         end
      end
   endtask

   // Pass 0: source 1 not ready until cycle 6. Pass 1: same, but source 1
   // is masked off so only the two wait states remain.
   task automatic test_ext_ready();
      stim_t s;
      exp_t  e, g;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 8; k++) begin
            s     = idle();
            s.en  = (p == 0) ? 2'b11 : 2'b01;
            s.rin = (k < 6) ? 2'b01 : 2'b11;
            if (k == 0) begin
               s.cs  = 1'b1;
               s.ws  = 4'd2;
               s.clr = 1'b1;
            end
            s.e_rdy = (p == 0) ? (k >= 6) : (k >= 2);
            s.e_st  = ~s.e_rdy;
            cyc(s);
            e = q.pop_front();
            g = {bus.rdy, bus.stalled, bus.timeout_flag, bus.stall_total};
            n_tests++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL ext_ready p%0d[%0d]: got rdy=%b stalled=%b tflag=%b total=%0d, want rdy=%b stalled=%b tflag=%b total=%0d",
                        p, k, g.rdy, g.stalled, g.tflag, g.total, e.rdy, e.stalled, e.tflag, e.total);
            end
         end
      end
   endtask

   // Pass 0: all sources low but masked -> no stall. Pass 1: enabled and
   // low with no wait states -> EXT until they rise.
   task automatic test_masked();
      stim_t s;
      exp_t  e, g;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 4; k++) begin
            s    = idle();
            s.cs = (p == 0) || (k == 0);
            s.ws = 4'd0;
            if (p == 0) begin
               s.rin = 2'b00;
               s.en  = 2'b00;
            end else begin
               s.rin = (k < 2) ? 2'b00 : 2'b11;
               s.e_rdy = (k >= 2);
               s.e_st  = (k < 2);
            end
            cyc(s);
            e = q.pop_front();
            g = {bus.rdy, bus.stalled, bus.timeout_flag, bus.stall_total};
            n_tests++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL masked p%0d[%0d]: got rdy=%b stalled=%b tflag=%b total=%0d, want rdy=%b stalled=%b tflag=%b total=%0d",
                        p, k, g.rdy, g.stalled, g.tflag, g.total, e.rdy, e.stalled, e.tflag, e.total);
            end
         end
      end
   endtask

   task automatic test_write_abort();
      stim_t s;
      exp_t  e, g;
      for (int k = 0; k < 10; k++) begin
         s = idle();
         case (k)
            0: begin s.cs = 1'b1; s.ws = 4'd7; end
            3: s.rw = 1'b0;                       // ws_cnt is 5 here
            5: begin s.cs = 1'b1; s.rw = 1'b0; s.ws = 4'd3; s.rin = 2'b00; end
            7: begin s.cs = 1'b1; s.rin = 2'b00; end
            8: begin s.rw = 1'b0; s.rin = 2'b00; end
            default: ;
         endcase
         s.e_rdy = !((k < 3) || (k == 7));
         s.e_st  = ~s.e_rdy;
         cyc(s);
         e = q.pop_front();
         g = {bus.rdy, bus.stalled, bus.timeout_flag, bus.stall_total};
         n_tests++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL write_abort[%0d]: got rdy=%b stalled=%b tflag=%b total=%0d, want rdy=%b stalled=%b tflag=%b total=%0d",
                     k, g.rdy, g.stalled, g.tflag, g.total, e.rdy, e.stalled, e.tflag, e.total);
         end
      end
   endtask

   // cyc_start while in WS must not reload the wait-state counter.
   task automatic test_back_to_back();
      stim_t s;
      exp_t  e, g;
      logic [6:0] cs_pat  = 7'b0111011;   // bit k = cyc_start at step k
      logic [6:0] rdy_pat = 7'b1010100;   // bit k = expected rdy after step k
      for (int k = 0; k < 7; k++) begin
         s       = idle();
         s.cs    = cs_pat[k];
         s.ws    = (k == 0) ? 4'd2 : ((k == 1) ? 4'd9 : 4'd1);
         s.e_rdy = rdy_pat[k];
         s.e_st  = ~rdy_pat[k];
         cyc(s);
         e = q.pop_front();
         g = {bus.rdy, bus.stalled, bus.timeout_flag, bus.stall_total};
         n_tests++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got rdy=%b stalled=%b tflag=%b total=%0d, want rdy=%b stalled=%b tflag=%b total=%0d",
                     k, g.rdy, g.stalled, g.tflag, g.total, e.rdy, e.stalled, e.tflag, e.total);
         end
      end
   endtask

   // Pass 0: EXT stall times out, then clear. Pass 1: clear on the timeout
   // edge (set wins). Pass 2: a 12-wait-state read is cut at 8.
   task automatic test_timeout();
      stim_t s;
      exp_t  e, g;
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 11; k++) begin
            s     = idle();
            s.rin = (p == 2) ? 2'b11 : 2'b00;
            if (k == 0) begin
               s.cs  = 1'b1;
               s.ws  = (p == 2) ? 4'd12 : 4'd0;
               s.clr = 1'b1;
            end
            if ((p == 0 && k == 10) || (p == 1 && k == 8)) s.clr = 1'b1;
            s.e_rdy = (k >= c_TO);
            s.e_st  = (k <  c_TO);
            s.e_to  = (k == c_TO);
            cyc(s);
            e = q.pop_front();
            g = {bus.rdy, bus.stalled, bus.timeout_flag, bus.stall_total};
            n_tests++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL timeout p%0d[%0d]: got rdy=%b stalled=%b tflag=%b total=%0d, want rdy=%b stalled=%b tflag=%b total=%0d",
                        p, k, g.rdy, g.stalled, g.tflag, g.total, e.rdy, e.stalled, e.tflag, e.total);
            end
         end
      end
   endtask

   // Three back-to-back timed-out stalls (24 low cycles) into a 4-bit count.
   task automatic test_saturate();
      stim_t s;
      exp_t  e, g;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k <= c_TO; k++) begin
            s     = idle();
            s.rin = 2'b00;
            s.cs  = (k == 0);
            s.clr = (r == 0) && (k == 0);
            s.e_rdy = (k == c_TO);
            s.e_st  = (k <  c_TO);
            s.e_to  = (k == c_TO);
            cyc(s);
            e = q.pop_front();
            g = {bus.rdy, bus.stalled, bus.timeout_flag, bus.stall_total};
            n_tests++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL saturate r%0d[%0d]: got rdy=%b stalled=%b tflag=%b total=%0d, want rdy=%b stalled=%b tflag=%b total=%0d",
                        r, k, g.rdy, g.stalled, g.tflag, g.total, e.rdy, e.stalled, e.tflag, e.total);
            end
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      stim_t s;
      exp_t  e, g;
      for (int k = 0; k < 6; k++) begin
         s = idle();
         case (k)
            0: begin s.cs = 1'b1; s.ws = 4'd5; end
            2: s.rst = 1'b1;
            4: begin s.cs = 1'b1; s.ws = 4'd1; end
            default: ;
         endcase
         s.e_rdy = !((k < 2) || (k == 4));
         s.e_st  = ~s.e_rdy;
         cyc(s);
         e = q.pop_front();
         g = {bus.rdy, bus.stalled, bus.timeout_flag, bus.stall_total};
         n_tests++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL reset_mid_stall[%0d]: got rdy=%b stalled=%b tflag=%b total=%0d, want rdy=%b stalled=%b tflag=%b total=%0d",
                     k, g.rdy, g.stalled, g.tflag, g.total, e.rdy, e.stalled, e.tflag, e.total);
         end
      end
   endtask

   initial begin
      bus.cyc_start   = 1'b0;
      bus.rw_n        = 1'b1;
      bus.ws_count    = '0;
      bus.READY_IN    = 2'b11;
      bus.ch_en       = 2'b11;
      bus.timeout_clr = 1'b0;
      test_reset();
      test_wait_states();
      test_ext_ready();
      test_masked();
      test_write_abort();
      test_back_to_back();
      test_timeout();
      test_saturate();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
